// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding, carry states and
// the default operand width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic S0 = 1'b0;
  localparam logic S1 = 1'b1;

  localparam int N_DEF = 8;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with its carry flop; the flop is the Mealy state of the
// serial adder (S0 = no carry pending, S1 = carry pending).
module serial_fa_cell
  import serial_add_pkg::*;
(
  input  logic i_clk,
  input  logic reset,
  input  logic load,
  input  logic init_carry,
  input  logic enable,
  input  logic a_bit,
  input  logic b_bit,
  output logic sum,
  output logic carry_out
);

  logic carry_reg;

  assign sum       = a_bit ^ b_bit ^ carry_reg;
  assign carry_out = (a_bit & b_bit) | (a_bit & carry_reg) | (b_bit & carry_reg);

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      carry_reg <= S0;
    end else if (load) begin
      carry_reg <= init_carry;
    end else if (enable) begin
      carry_reg <= carry_out;
    end
  end

endmodule

// File: rtl/serial_add_core.sv
// Bit-serial adder front end: captures two operands on start, shifts them out
// LSB-first through a full-adder cell and reports carry-out and completion.
module serial_add_core
  import serial_add_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         i_clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         cin,
  output logic         sum_bit,
  output logic         shift_s,
  output logic         busy,
  output logic         done,
  output logic         cout
);

  localparam int CW = $clog2(N);

  state_t        state_reg, state_next;
  logic [N-1:0]  a_sh_reg, b_sh_reg;
  logic [N-1:0]  a_shr, b_shr;
  logic [CW-1:0] count_reg;
  logic          cout_reg;
  logic          load, running, last_bit;
  logic          fa_sum, fa_carry;

  // Right shift with zero fill into the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_shr
      if (gi == N - 1) begin : g_msb
        assign a_shr[gi] = 1'b0;
        assign b_shr[gi] = 1'b0;
      end else begin : g_bit
        assign a_shr[gi] = a_sh_reg[gi+1];
        assign b_shr[gi] = b_sh_reg[gi+1];
      end
    end
  endgenerate

  serial_fa_cell u_fa (
    .i_clk      (i_clk),
    .reset      (reset),
    .load       (load),
    .init_carry (cin),
    .enable     (running),
    .a_bit      (a_sh_reg[0]),
    .b_bit      (b_sh_reg[0]),
    .sum        (fa_sum),
    .carry_out  (fa_carry)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    running    = 1'b0;
    last_bit   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        running  = 1'b1;
        last_bit = (count_reg == CW'(N - 1));
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      count_reg <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        a_sh_reg  <= a_in;
        b_sh_reg  <= b_in;
        count_reg <= '0;
      end else if (running) begin
        a_sh_reg <= a_shr;
        b_sh_reg <= b_shr;
        // Hold at the last index so the counter never wraps within an operation.
        if (!last_bit) begin
          count_reg <= count_reg + 1'b1;
        end
      end
      if (last_bit) begin
        cout_reg <= fa_carry;
      end
    end
  end

  assign sum_bit = running & fa_sum;
  assign shift_s = (state_reg == RUN);
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign cout    = cout_reg;

endmodule

// File: tb/tb_serial_add_core.sv
// Self-checking bench for serial_add_core: directed vector table, hand-written
// corner sequences and randomized operands against an arithmetic model.
module tb_serial_add_core;

  localparam int N = 8;

  logic         i_clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] a_in, b_in;
  logic         cin;
  logic         sum_bit, shift_s, busy, done, cout;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  serial_add_core #(.N(N)) dut (
    .i_clk   (i_clk),
    .reset   (reset),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .sum_bit (sum_bit),
    .shift_s (shift_s),
    .busy    (busy),
    .done    (done),
    .cout    (cout)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c;
    logic [N-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start one operation and watch it for N+3 cycles. Cycle k (k>=1) is the
  // k-th cycle after the accepting edge; outputs are sampled at its negedge.
  // If poke_cyc >= 1, a stray start with other operands is raised in that cycle.
  task automatic apply_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                          input int poke_cyc,
                          output logic [N-1:0] sum_o, output int nshift,
                          output int done_cyc, output logic cout_o,
                          output int stray_sum);
    @(negedge i_clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(posedge i_clk);
    #1 start = 1'b0;
    sum_o = '0; nshift = 0; done_cyc = -1; cout_o = 1'b0; stray_sum = 0;
    for (int cyc = 1; cyc <= N + 3; cyc++) begin
      @(negedge i_clk);
      if (shift_s) begin
        if (nshift < N) sum_o[nshift] = sum_bit;
        nshift++;
      end else if (sum_bit) begin
        stray_sum++;
      end
      if (done && done_cyc < 0) begin
        done_cyc = cyc;
        cout_o   = cout;
      end
      if (cyc == poke_cyc) begin
        start = 1'b1; a_in = ~a; b_in = ~b; cin = ~c;
      end else if (cyc == poke_cyc + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic c, input logic [N-1:0] exp_sum, input logic exp_cout,
                               input int poke_cyc);
    logic [N-1:0] s;
    int           ns, dc, stray;
    logic         co;
    apply_op(a, b, c, poke_cyc, s, ns, dc, co, stray);
    $display("op %s: %02h + %02h + %0d -> sum %02h cout %0d (shift %0d, done@%0d)",
             tag, a, b, c, s, co, ns, dc);
    check({tag, " sum"}, int'(s), int'(exp_sum));
    check({tag, " cout"}, int'(co), int'(exp_cout));
    check({tag, " shift_len"}, ns, N);
    check({tag, " done_cycle"}, dc, N + 1);
    check({tag, " sum_outside_run"}, stray, 0);
    check({tag, " idle_after"}, int'(busy), 0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [N-1:0] ra, rb;
    logic         rc;
    logic [N:0]   model;
    logic [N-1:0] s1, s2;
    int           n1, n2, gap, win, first_start, cyc;
    logic         c1, c2, prev_shift;

    vecs[0] = '{8'h35, 8'h5A, 1'b0, 8'h8F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

    // Reset state without relying on a clock edge.
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    #1;
    check("reset outputs", int'({sum_bit, shift_s, busy, done, cout}), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
                    vecs[i].exp_sum, vecs[i].exp_cout, -10);
    end

    // Start raised mid-RUN must not disturb or queue anything.
    run_and_check("ignored_start", 8'h35, 8'h5A, 1'b0, 8'h8F, 1'b0, 4);

    // Asynchronous reset between edges in RUN cycle 5.
    @(negedge i_clk);
    a_in = 8'h35; b_in = 8'h5A; cin = 1'b0; start = 1'b1;
    @(posedge i_clk);
    #1 start = 1'b0;
    repeat (4) @(posedge i_clk);
    #3;
    check("mid_reset pre busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    $display("op mid_reset: outputs after reset = %05b", {sum_bit, shift_s, busy, done, cout});
    check("mid_reset outputs", int'({sum_bit, shift_s, busy, done, cout}), 0);
    @(negedge i_clk);
    reset = 1'b0;
    @(negedge i_clk);
    check("mid_reset idle", int'(busy), 0);
    run_and_check("post_reset", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, -10);

    // Back-to-back with start held high; operands for op 2 change after op 1 is accepted.
    @(negedge i_clk);
    a_in = 8'h80; b_in = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge i_clk);
    #1;
    s1 = '0; s2 = '0; n1 = 0; n2 = 0; gap = 0; win = 0; c1 = 1'b0; c2 = 1'b0;
    first_start = -1; prev_shift = 1'b0;
    for (cyc = 1; cyc <= 2 * N + 6; cyc++) begin
      @(negedge i_clk);
      if (cyc == 1) begin a_in = 8'h0F; b_in = 8'h01; end
      if (shift_s && !prev_shift) begin
        win++;
        if (win == 1) first_start = cyc;
      end
      if (shift_s && win == 1) begin if (n1 < N) s1[n1] = sum_bit; n1++; end
      if (shift_s && win == 2) begin
        if (n2 < N) s2[n2] = sum_bit; n2++;
        start = 1'b0;
      end
      if (win == 1 && !busy) gap++;
      if (done && win == 1) c1 = cout;
      if (done && win == 2) c2 = cout;
      prev_shift = shift_s;
    end
    start = 1'b0;
    $display("op back_to_back: %02h cout %0d then %02h cout %0d, idle gap %0d, windows %0d",
             s1, c1, s2, c2, gap, win);
    check("b2b first_start", first_start, 1);
    check("b2b sum1", int'(s1), 8'h00);
    check("b2b cout1", int'(c1), 1);
    check("b2b len1", n1, N);
    check("b2b sum2", int'(s2), 8'h10);
    check("b2b cout2", int'(c2), 0);
    check("b2b len2", n2, N);
    check("b2b idle_gap", gap, 1);
    check("b2b windows", win, 2);

    // Randomized operands against plain integer addition.
    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
      run_and_check($sformatf("rand%0d", i), ra, rb, rc, model[N-1:0], model[N], -10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_add_core.md
Name: serial_add_core

Overview:
- Upstream stage of the 8-bit serial adder datapath: a Mealy-machine bit-serial full adder with operand shift registers, a carry state flop and a bit counter.
- Loads two parallel operands on a start handshake and shifts them out LSB-first.
- Produces one sum bit per cycle, together with the shift-enable strobe consumed by the sum shift register.
- Reports carry-out and completion.

Parameters:
- N, 8, operand/sum width in bits (N >= 2).
- CW, $clog2(N), bit-counter width (derived, not overridden).

Ports:
- i_clk  input  1  system clock, all flops on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a_in  input  N  operand A, captured on accepted start.
- b_in  input  N  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- sum_bit  output  1  current serial sum bit (Mealy, combinational), LSB first; drives downstream w3.
- shift_s  output  1  high for exactly N consecutive cycles while sum_bit is valid.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse after the Nth bit.
- cout  output  1  registered final carry, valid from DONE until the next accepted start.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, operand regs=0, carry=0, count=0, cout=0.
  - All outputs read 0 immediately, with no clock required.
- Control FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge loads a_sh<=a_in, b_sh<=b_in, carry<=cin, count<=0, next=RUN. start=0 stays IDLE.
  - RUN: every edge does the following:
    - a_sh<=a_sh>>1 and b_sh<=b_sh>>1, zero-filling the MSB.
    - carry<=maj(a_sh[0],b_sh[0],carry).
    - count<=count+1.
    - When count==N-1: next=DONE, cout<=maj(a_sh[0],b_sh[0],carry).
  - DONE: lasts one cycle, then next=IDLE.
- Carry flop is the Mealy state: S0 (carry=0), S1 (carry=1).
  - sum_bit = a_sh[0]^b_sh[0]^carry in RUN.
  - sum_bit is forced to 0 in IDLE and DONE.
- Outputs per state:
  - shift_s = (state==RUN). busy = (state!=IDLE). done = (state==DONE).
- Latency:
  - start accepted at edge 0.
  - Bit i is valid during cycle i+1, for i=0..N-1.
  - done is high in cycle N+1; IDLE resumes at cycle N+2.
  - Downstream has captured all N sum bits by the edge ending cycle N.
- Start rules:
  - start is ignored in RUN and DONE; no queuing.
  - start held high continuously gives back-to-back operations separated by one IDLE cycle.
- Operands are not re-sampled during RUN, so a_in, b_in and cin may change freely after acceptance.
- Arithmetic is modulo 2^N. Overflow appears only on cout.
- Counter stops at N-1 and never wraps past N-1 within an operation.

Decomposition:
- Package serial_add_pkg holds:
  - The state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Carry-state constants S0/S1.
  - The default width constant N_DEF=8.
- One sub-module is natural: serial_fa_cell.
  - Contents: combinational sum/majority plus the carry flop.
  - Ports: load, init carry, enable, async reset.
- The operand shift registers, counter and FSM stay in serial_add_core.

Test Plan:
1. Basic add: a_in=8'h35, b_in=8'h5A, cin=0, start pulse.
   - sum_bit sequence over the 8 shift_s cycles, LSB first, is 1,1,1,1,0,0,0,1 (8'h8F).
   - cout=0; done pulses in cycle 9.
2. Carry ripple and overflow: 8'hFF + 8'h01, cin=0.
   - Serial sum is 8'h00; cout=1 from DONE onward.
3. Carry-in only: 8'h00 + 8'h00, cin=1.
   - Serial sum is 8'h01; carry returns to S0 after bit 0; cout=0.
4. Ignored start: start pulsed again in RUN cycle 4 with different operands.
   - The current result is unchanged (8'h8F for scenario 1 operands).
   - shift_s stays high exactly 8 cycles; no second operation begins.
5. Reset mid-operation: assert reset asynchronously between edges during RUN cycle 5.
   - shift_s, sum_bit, busy, done and cout go to 0 immediately.
   - After release the FSM is in IDLE; a new start of 8'h12 + 8'h34 yields 8'h46.
6. Back-to-back: start held high for two operations, 8'h80+8'h80 then 8'h0F+8'h01.
   - Results are 8'h00 with cout=1, then 8'h10 with cout=0.
   - Exactly one IDLE cycle separates the two shift_s windows.
